switch_conditioner: RTL and testbench

Upstream input-conditioning stage for the board's push-button switches. It synchronizes the raw asynchronous switch pin, debounces it with a consecutive-sample counter, and produces a clean level plus single-cycle press, release and long-press pulses. Downstream edge-driven logic, such as LED toggles and mode selection, consumes these outputs directly and needs no local edge detector of its own.

---
 rtl/switch_conditioner.sv | 188 ++++++++++++++++++
 tb/tb_switch_conditioner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : switch_conditioner
// Description : Push-button input conditioner. Synchronizes the raw switch
//               pin, debounces it with a consecutive-sample counter and
//               produces a clean level plus single-cycle press, release and
//               long-press pulses.
// Ports       : i_Clk        - system clock (only clock)
//               i_Rst_L      - asynchronous active-low reset
//               i_Switch     - raw asynchronous switch pin, 1 = pressed
//               o_Switch     - debounced switch level
//               o_Press      - 1-cycle pulse with the 0->1 change of o_Switch
//               o_Release    - 1-cycle pulse with the 1->0 change of o_Switch
//               o_Long_Press - 1-cycle pulse once LONG_LIMIT cycles of
//                              continuous o_Switch=1 have elapsed
// Revision    : 1.0 - initial release
// ============================================================================
module switch_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int LONG_LIMIT     = 25000000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long_Press
);

  localparam int c_DB_W   = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int c_HOLD_W = $clog2(LONG_LIMIT + 1);

  // Counter value seen on the edge *before* the limit is reached; matching it
  // means the increment on this edge completes the count.
  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_LIMIT - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(LONG_LIMIT);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [c_DB_W-1:0]      r_db_cnt;
  logic [c_DB_W-1:0]      w_db_cnt_next;
  logic                   w_switch_next;

  logic [c_HOLD_W-1:0]    r_hold;
  logic                   r_switch;
  logic                   r_press;
  logic                   r_release;
  logic                   r_long;

  // --------------------------------------------------------------------------
  // Input synchronizer: only the last stage is used by the debounce logic.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_Switch};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Debounce FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state  <= S_LOW;
      r_db_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_db_cnt <= w_db_cnt_next;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM: next state and counter. A single differing sample during a
  // check state sends the FSM back to the stable state, so only an unbroken
  // run of DEBOUNCE_LIMIT new-level samples changes the debounced level.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_db_cnt_next = r_db_cnt;
    case (r_state)
      S_LOW: begin
        if (w_sync) begin
          if (DEBOUNCE_LIMIT == 1) begin
            w_state_next  = S_HIGH;
            w_db_cnt_next = '0;
          end else begin
            w_state_next  = S_RISE_CHK;
            w_db_cnt_next = c_DB_ONE;
          end
        end
      end
      S_RISE_CHK: begin
        if (!w_sync) begin
          w_state_next  = S_LOW;
          w_db_cnt_next = '0;
        end else if (r_db_cnt == c_DB_LAST) begin
          w_state_next  = S_HIGH;
          w_db_cnt_next = '0;
        end else begin
          w_db_cnt_next = r_db_cnt + c_DB_ONE;
        end
      end
      S_HIGH: begin
        if (!w_sync) begin
          if (DEBOUNCE_LIMIT == 1) begin
            w_state_next  = S_LOW;
            w_db_cnt_next = '0;
          end else begin
            w_state_next  = S_FALL_CHK;
            w_db_cnt_next = c_DB_ONE;
          end
        end
      end
      S_FALL_CHK: begin
        if (w_sync) begin
          w_state_next  = S_HIGH;
          w_db_cnt_next = '0;
        end else if (r_db_cnt == c_DB_LAST) begin
          w_state_next  = S_LOW;
          w_db_cnt_next = '0;
        end else begin
          w_db_cnt_next = r_db_cnt + c_DB_ONE;
        end
      end
      default: begin
        w_state_next  = S_LOW;
        w_db_cnt_next = '0;
      end
    endcase
  end

  // The level follows the *next* state so o_Switch changes on the same edge
  // as the transition into S_HIGH / S_LOW.
  assign w_switch_next = (w_state_next == S_HIGH) || (w_state_next == S_FALL_CHK);

  // --------------------------------------------------------------------------
  // Registered outputs and hold counter. The hold counter is held at zero
  // while the level is low, so it is zero right after the rising edge, and it
  // keeps counting through S_FALL_CHK. It saturates at LONG_LIMIT so the
  // long-press match can occur only once per press. A release on the same
  // edge as the match suppresses the long-press pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_switch  <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_switch  <= w_switch_next;
      r_press   <= w_switch_next & ~r_switch;
      r_release <= ~w_switch_next & r_switch;
      r_long    <= r_switch & w_switch_next & (r_hold == c_HOLD_LAST);
      if (!r_switch) begin
        r_hold <= '0;
      end else if (r_hold != c_HOLD_MAX) begin
        r_hold <= r_hold + c_HOLD_ONE;
      end
    end
  end

  assign o_Switch     = r_switch;
  assign o_Press      = r_press;
  assign o_Release    = r_release;
  assign o_Long_Press = r_long;

endmodule
`default_nettype wire

// File: tb/tb_switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_conditioner
// Description : Self-checking bench for switch_conditioner. A behavioural
//               model (delay pipe + run-length counter + hold counter) is
//               compared against the DUT every cycle, plus directed checks of
//               latency, bounce rejection, long/short press and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_conditioner;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int LL = 20;

  logic i_Clk   = 1'b0;
  logic i_Rst_L = 1'b0;
  logic i_Switch = 1'b0;
  logic o_Switch, o_Press, o_Release, o_Long_Press;

  int n_checks = 0;
  int n_err    = 0;

  switch_conditioner #(
    .SYNC_STAGES   (SS),
    .DEBOUNCE_LIMIT(DB),
    .LONG_LIMIT    (LL)
  ) u_dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Switch    (i_Switch),
    .o_Switch    (o_Switch),
    .o_Press     (o_Press),
    .o_Release   (o_Release),
    .o_Long_Press(o_Long_Press)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: the pin reaches the debouncer SS edges late; the level
  // flips once DB consecutive delayed samples disagree with it; the hold
  // count is the number of edges spent high since the rise.
  // --------------------------------------------------------------------------
  logic [SS-1:0] m_pipe  = '0;
  logic          m_level = 1'b0;
  int            m_run   = 0;
  int            m_hold  = 0;
  logic          m_press = 1'b0;
  logic          m_rel   = 1'b0;
  logic          m_long  = 1'b0;

  always @(posedge i_Clk or negedge i_Rst_L) begin
    logic seen;
    logic old;
    if (!i_Rst_L) begin
      m_pipe = '0; m_level = 1'b0; m_run = 0; m_hold = 0;
      m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    end else begin
      seen   = m_pipe[SS-1];
      m_pipe = {m_pipe[SS-2:0], i_Switch};
      old    = m_level;
      m_long = 1'b0;
      if (seen != m_level) begin
        m_run++;
        if (m_run >= DB) begin
          m_level = seen;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_press = !old && m_level;
      m_rel   = old && !m_level;
      if (!old) begin
        m_hold = 0;
      end else if (m_hold < LL) begin
        m_hold++;
        if (m_hold == LL && m_level) m_long = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle comparison and pulse bookkeeping, sampled on the falling edge.
  // --------------------------------------------------------------------------
  logic chk_en = 1'b0;
  int   cyc = 0;
  int   n_press = 0, n_rel = 0, n_long = 0;
  int   press_cyc = 0, long_cyc = 0;

  always @(negedge i_Clk) begin
    cyc++;
    if (chk_en) begin
      check("model_switch",  o_Switch,     m_level);
      check("model_press",   o_Press,      m_press);
      check("model_release", o_Release,    m_rel);
      check("model_long",    o_Long_Press, m_long);
      check("press_rel_excl", o_Press & o_Release, 0);
      if (o_Press)      begin n_press++; press_cyc = cyc; end
      if (o_Release)    n_rel++;
      if (o_Long_Press) begin n_long++; long_cyc = cyc; end
    end
  end

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_long = 0;
  endtask

  task automatic wait_press();
    int i;
    i = 0;
    do begin
      @(negedge i_Clk);
      i++;
    end while (!o_Press && i < 50);
    check("press_wait", o_Press, 1);
  endtask

  // Press, hold `extra` cycles past the press, release, then settle.
  task automatic hold_then_release(input int extra);
    clear_counts();
    i_Switch = 1'b1;
    wait_press();
    repeat (extra) @(negedge i_Clk);
    i_Switch = 1'b0;
    repeat (12) @(negedge i_Clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge i_Clk);
    check("rst_switch",  o_Switch,     0);
    check("rst_press",   o_Press,      0);
    check("rst_release", o_Release,    0);
    check("rst_long",    o_Long_Press, 0);
    chk_en  = 1'b1;
    i_Rst_L = 1'b1;
    repeat (4) @(negedge i_Clk);

    // Clean press: new level sampled on edge t, o_Switch rises on edge t+5
    i_Switch = 1'b1;
    repeat (5) @(negedge i_Clk);
    check("press_early_sw", o_Switch, 0);
    @(negedge i_Clk);
    check("press_sw",    o_Switch, 1);
    check("press_pulse", o_Press,  1);
    @(negedge i_Clk);
    check("press_pulse_end", o_Press, 0);

    // Release from stable high
    repeat (3) @(negedge i_Clk);
    i_Switch = 1'b0;
    repeat (5) @(negedge i_Clk);
    check("rel_early_sw", o_Switch, 1);
    @(negedge i_Clk);
    check("rel_sw",    o_Switch,  0);
    check("rel_pulse", o_Release, 1);
    @(negedge i_Clk);
    check("rel_pulse_end", o_Release, 0);
    repeat (30) @(negedge i_Clk);

    // Bounce rejection
    clear_counts();
    i_Switch = 1'b1; repeat (3) @(negedge i_Clk);
    i_Switch = 1'b0; repeat (2) @(negedge i_Clk);
    i_Switch = 1'b1; repeat (3) @(negedge i_Clk);
    i_Switch = 1'b0; repeat (12) @(negedge i_Clk);
    check("bounce_sw",    o_Switch, 0);
    check("bounce_press", n_press, 0);
    check("bounce_rel",   n_rel,   0);
    check("bounce_long",  n_long,  0);

    // Long press: 40 cycles high
    clear_counts();
    i_Switch = 1'b1; repeat (40) @(negedge i_Clk);
    i_Switch = 1'b0; repeat (12) @(negedge i_Clk);
    check("long_count", n_long, 1);
    check("long_delay", long_cyc - press_cyc, LL);
    check("long_press", n_press, 1);
    check("long_rel",   n_rel,   1);
    repeat (10) @(negedge i_Clk);

    // Short press: 12 cycles past the press
    hold_then_release(12);
    check("short_press", n_press, 1);
    check("short_rel",   n_rel,   1);
    check("short_long",  n_long,  0);

    // Release lands on the very edge the hold count reaches the limit
    hold_then_release(14);
    check("tie_long", n_long, 0);
    check("tie_rel",  n_rel,  1);

    // Release one edge later: the long press fires first
    hold_then_release(15);
    check("late_long", n_long, 1);
    check("late_rel",  n_rel,  1);

    // Async reset mid-cycle while high, then release of reset with pin held
    i_Switch = 1'b1;
    wait_press();
    repeat (3) @(negedge i_Clk);
    @(posedge i_Clk);
    #2 i_Rst_L = 1'b0;
    #1;
    check("arst_switch",  o_Switch,     0);
    check("arst_press",   o_Press,      0);
    check("arst_release", o_Release,    0);
    check("arst_long",    o_Long_Press, 0);
    repeat (2) @(negedge i_Clk);
    i_Rst_L = 1'b1;
    repeat (5) @(negedge i_Clk);
    check("arst_press_early", o_Press, 0);
    @(negedge i_Clk);
    check("arst_press_6", o_Press, 1);
    repeat (5) @(negedge i_Clk);

    // Randomized segments, with occasional mid-cycle resets
    for (int s = 0; s < 300; s++) begin
      i_Switch = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        @(posedge i_Clk);
        #3 i_Rst_L = 1'b0;
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
      end
      repeat ($urandom_range(1, 30)) @(negedge i_Clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
